// File: rtl/radar_mode_sched.sv
// radar_mode_sched: steps timing_gen through a table of (mode, CPI count)
// slots. Mode changes happen only at CPI boundaries and are followed by a
// fixed dead gap with the generator disabled.
// Optional cpie watchdog: define SCHED_WATCHDOG_EN.
//
// state | meaning
// IDLE  | stopped, table writable
// LOAD  | fetch table[slot], skip slots with a zero count
// GAP   | new mode_t applied, generator held disabled for GAP cycles
// RUN   | generator enabled, counting cpie pulses
// NEXT  | advance slot, wrap (loop) or finish
// DONE  | one-cycle done pulse
module radar_mode_sched #(
    parameter int SLOTS    = 8,
    parameter int ADDR_W   = 3,
    parameter int CNT_W    = 16,
    parameter int GAP      = 16,
    parameter int WDOG_CYC = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W+7:0]  cfg_wdata,
    input  logic [ADDR_W:0]   sched_len,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    input  logic              cpie,
    output logic [7:0]        mode_t,
    output logic              tg_enable,
    output logic              busy,
    output logic [ADDR_W-1:0] cur_slot,
    output logic [CNT_W-1:0]  cpi_cnt,
    output logic              done,
    output logic              cfg_err,
    output logic              wdog_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_NEXT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam int                GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LD   = GAP_W'(GAP - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   SLOTS_L  = SLOTS[ADDR_W:0];
    localparam logic [ADDR_W:0]   SLOT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [ADDR_W:0]   slot;
    logic [ADDR_W:0]   skip_cnt;
    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W:0]   slot_inc;
    logic [ADDR_W:0]   skip_inc;
    logic [7:0]        tbl_mode [SLOTS];
    logic [CNT_W-1:0]  tbl_cnt  [SLOTS];
    logic [7:0]        rd_mode;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  ent_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [GAP_W-1:0]  gap_cnt;
    logic              stop_pend;
    logic              addr_ok;
    logic              wr_bad;
    logic              wdog_fire;

    // Lengths beyond the table size are clamped to the table size.
    assign len_eff  = (sched_len > SLOTS_L) ? SLOTS_L : sched_len;
    assign slot_inc = slot + SLOT_ONE;
    assign skip_inc = skip_cnt + SLOT_ONE;
    assign rd_mode  = tbl_mode[slot[ADDR_W-1:0]];
    assign rd_cnt   = tbl_cnt[slot[ADDR_W-1:0]];
    assign cnt_inc  = (cpi_cnt == '1) ? cpi_cnt : cpi_cnt + CNT_ONE;

    generate
        if (SLOTS >= (1 << ADDR_W)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = ({1'b0, cfg_addr} < SLOTS_L);
        end
    endgenerate

    assign wr_bad    = cfg_we && (busy || !addr_ok);
    assign tg_enable = (state == S_RUN);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign cur_slot  = slot[ADDR_W-1:0];

`ifdef SCHED_WATCHDOG_EN
    localparam int             WD_W   = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LD  = WD_W'(WDOG_CYC - 1);
    localparam logic [WD_W-1:0] WD_ONE = {{(WD_W-1){1'b0}}, 1'b1};

    logic [WD_W-1:0] wdog_cnt;
    logic            wdog_err_r;
    logic            run_entry;

    assign run_entry = (state == S_GAP) && !stop && (gap_cnt == '0);
    assign wdog_fire = (state == S_RUN) && !cpie && (wdog_cnt == '0);
    assign wdog_err  = wdog_err_r;

    // Down-counter of RUN cycles since RUN entry or the last cpie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt   <= '0;
            wdog_err_r <= 1'b0;
        end else begin
            wdog_err_r <= wdog_fire;
            if (run_entry || cpie)
                wdog_cnt <= WD_LD;
            else if ((state == S_RUN) && (wdog_cnt != '0))
                wdog_cnt <= wdog_cnt - WD_ONE;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    // Schedule table; writes only while idle, anything else is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                tbl_mode[i] <= '0;
                tbl_cnt[i]  <= '0;
            end
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= wr_bad;
            if (cfg_we && !wr_bad) begin
                tbl_mode[cfg_addr] <= cfg_wdata[7:0];
                tbl_cnt[cfg_addr]  <= cfg_wdata[CNT_W+7:8];
            end
        end
    end

    // Sequencing FSM; skip_cnt counts consecutive empty slots so an all-empty
    // looping schedule still terminates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            slot      <= '0;
            skip_cnt  <= '0;
            mode_t    <= '0;
            ent_cnt   <= '0;
            cpi_cnt   <= '0;
            gap_cnt   <= '0;
            stop_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !stop && (len_eff != '0)) begin
                        slot      <= '0;
                        skip_cnt  <= '0;
                        stop_pend <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (rd_cnt == '0) begin
                        skip_cnt <= skip_inc;
                        if (skip_inc >= len_eff)
                            state <= S_DONE;
                        else if (slot_inc >= len_eff) begin
                            if (loop) slot  <= '0;
                            else      state <= S_DONE;
                        end else
                            slot <= slot_inc;
                    end else begin
                        mode_t   <= rd_mode;
                        ent_cnt  <= rd_cnt;
                        cpi_cnt  <= '0;
                        skip_cnt <= '0;
                        gap_cnt  <= GAP_LD;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (stop)
                        state <= S_IDLE;
                    else if (gap_cnt == '0)
                        state <= S_RUN;
                    else
                        gap_cnt <= gap_cnt - GAP_ONE;
                end
                S_RUN: begin
                    if (wdog_fire) begin
                        stop_pend <= 1'b0;
                        state     <= S_IDLE;
                    end else if (cpie) begin
                        cpi_cnt <= cnt_inc;
                        if (stop || stop_pend) begin
                            stop_pend <= 1'b0;
                            state     <= S_IDLE;
                        end else if (cnt_inc >= ent_cnt)
                            state <= S_NEXT;
                    end else if (stop)
                        stop_pend <= 1'b1;
                end
                S_NEXT: begin
                    if (stop)
                        state <= S_IDLE;
                    else if (slot_inc >= len_eff) begin
                        if (loop) begin
                            slot  <= '0;
                            state <= S_LOAD;
                        end else
                            state <= S_DONE;
                    end else begin
                        slot  <= slot_inc;
                        state <= S_LOAD;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_radar_mode_sched.sv
// Scoreboard bench for radar_mode_sched: expected output events are queued
// as stimulus is applied and matched when the DUT produces them.
module tb_radar_mode_sched;

    localparam int SLOTS  = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 16;
    localparam int GAP    = 16;
    localparam int WDOG   = 1000;

    localparam int EV_NONE = 0;
    localparam int EV_RISE = 1;
    localparam int EV_DONE = 2;
    localparam int EV_IDLE = 3;
    localparam int EV_CFG  = 4;
    localparam int EV_WDOG = 5;

    typedef struct {
        int kind;
        int mode;
        int slot;
        int cnt;
    } ev_t;

    logic              clk;
    logic              rst_n;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [CNT_W+7:0]  cfg_wdata;
    logic [ADDR_W:0]   sched_len;
    logic              loop;
    logic              start;
    logic              stop;
    logic              cpie;
    logic [7:0]        mode_t;
    logic              tg_enable;
    logic              busy;
    logic [ADDR_W-1:0] cur_slot;
    logic [CNT_W-1:0]  cpi_cnt;
    logic              done;
    logic              cfg_err;
    logic              wdog_err;

    logic              cpie_a;
    logic              cpie_m;
    logic              auto_en;
    int                n_chk;
    int                n_fail;
    ev_t               exp_q[$];
    int                since_mode;
    int                run_cyc;
    logic              prev_en;
    logic              prev_busy;
    logic [7:0]        mode_prev;

    assign cpie = cpie_a | cpie_m;

    radar_mode_sched #(
        .SLOTS(SLOTS), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .GAP(GAP), .WDOG_CYC(WDOG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .sched_len(sched_len), .loop(loop),
        .start(start), .stop(stop), .cpie(cpie), .mode_t(mode_t),
        .tg_enable(tg_enable), .busy(busy), .cur_slot(cur_slot),
        .cpi_cnt(cpi_cnt), .done(done), .cfg_err(cfg_err), .wdog_err(wdog_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input int mode, input int slot, input int cnt);
        ev_t e;
        e.kind = kind;
        e.mode = mode;
        e.slot = slot;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic take_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, EV_NONE);
            return;
        end
        e = exp_q.pop_front();
        chk("ev_kind", kind, e.kind);
        if (kind != e.kind) return;
        case (kind)
            EV_RISE: begin
                chk("rise_mode", int'(mode_t), e.mode);
                chk("rise_slot", int'(cur_slot), e.slot);
                chk("gap_len", since_mode, GAP);
                chk("rise_cpi_cnt", int'(cpi_cnt), 0);
            end
            EV_DONE: begin
                chk("done_mode", int'(mode_t), e.mode);
                if (e.cnt >= 0) chk("done_cpi_cnt", int'(cpi_cnt), e.cnt);
            end
            EV_IDLE: begin
                chk("idle_enable", int'(tg_enable), 0);
                chk("idle_done", int'(done), 0);
            end
            EV_WDOG: begin
                chk("wdog_cycle", run_cyc, WDOG);
                chk("wdog_enable", int'(tg_enable), 0);
            end
            default: ;
        endcase
    endtask

    // Output monitor: turns DUT activity into events for the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en    = 1'b0;
            prev_busy  = 1'b0;
            mode_prev  = mode_t;
            since_mode = 0;
            run_cyc    = 0;
        end else begin
            if (mode_t != mode_prev) since_mode = 0;
            else since_mode++;
            mode_prev = mode_t;
            run_cyc++;
            if (cfg_err) take_ev(EV_CFG);
            if (tg_enable && !prev_en) begin
                take_ev(EV_RISE);
                run_cyc = 0;
            end
            if (wdog_err) take_ev(EV_WDOG);
            if (done) take_ev(EV_DONE);
            if (!busy && prev_busy) take_ev(EV_IDLE);
            prev_en   = tg_enable;
            prev_busy = busy;
        end
    end

    // cpie source: one pulse every 200 enabled cycles, phase reset when disabled.
    initial begin
        int cyc;
        cyc    = 0;
        cpie_a = 1'b0;
        forever begin
            @(negedge clk);
            if (tg_enable && auto_en && rst_n) cyc++;
            else cyc = 0;
            cpie_a = (cyc == 200);
            if (cyc == 200) cyc = 0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input int c, input int m);
        cfg_we    = 1'b1;
        cfg_addr  = ADDR_W'(a);
        cfg_wdata = {CNT_W'(c), 8'(m)};
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic go(input int len, input logic lp);
        sched_len = (ADDR_W+1)'(len);
        loop      = lp;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_q(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while ((exp_q.size() > n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk(tag, exp_q.size(), n);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        sched_len = '0;
        loop      = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        cpie_m    = 1'b0;
        auto_en   = 1'b1;

        cycles(3);
        chk("rst_mode_t", int'(mode_t), 0);
        chk("rst_enable", int'(tg_enable), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cur_slot", int'(cur_slot), 0);
        chk("rst_cpi_cnt", int'(cpi_cnt), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        cycles(2);

        // Two-slot schedule, no loop.
        wr(0, 3, 1);
        wr(1, 2, 5);
        push(EV_RISE, 1, 0, 0);
        push(EV_RISE, 5, 1, 0);
        push(EV_DONE, 5, 0, 2);
        push(EV_IDLE, 0, 0, 0);
        go(2, 1'b0);
        wait_q(0, 3000, "basic_sched_events");
        cycles(5);
        chk("basic_mode_hold", int'(mode_t), 5);
        chk("basic_busy", int'(busy), 0);

        // Looping schedule, stopped mid-CPI after wrapping to slot 0.
        push(EV_RISE, 1, 0, 0);
        push(EV_RISE, 5, 1, 0);
        push(EV_RISE, 1, 0, 0);
        go(2, 1'b1);
        wait_q(0, 3000, "loop_wrap_events");
        push(EV_IDLE, 0, 0, 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_pending_enable", int'(tg_enable), 1);
        cycles(2);
        chk("stop_pending_busy", int'(busy), 1);
        wait_q(0, 400, "stop_idle_event");

        // Empty slot 0 is skipped.
        wr(0, 0, 9);
        wr(1, 1, 2);
        push(EV_RISE, 2, 1, 0);
        push(EV_DONE, 2, 0, 1);
        push(EV_IDLE, 0, 0, 0);
        go(2, 1'b0);
        wait_q(0, 1000, "skip_events");

        // All slots empty with loop: must finish.
        wr(1, 0, 2);
        push(EV_DONE, 2, 0, -1);
        push(EV_IDLE, 0, 0, 0);
        go(2, 1'b1);
        wait_q(0, 100, "all_empty_events");

        // Write while busy is rejected.
        wr(0, 3, 1);
        wr(1, 2, 5);
        push(EV_RISE, 1, 0, 0);
        push(EV_CFG, 0, 0, 0);
        push(EV_RISE, 5, 1, 0);
        push(EV_DONE, 5, 0, 2);
        push(EV_IDLE, 0, 0, 0);
        go(2, 1'b0);
        wait_q(4, 500, "busy_wr_first_rise");
        wr(1, 1, 7);
        wait_q(0, 3000, "busy_wr_events");

        // Zero length start and start+stop together are ignored.
        go(0, 1'b0);
        cycles(3);
        chk("len0_busy", int'(busy), 0);
        sched_len = 4'd2;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        cycles(2);
        chk("start_stop_busy", int'(busy), 0);

`ifdef SCHED_WATCHDOG_EN
        auto_en = 1'b0;
        push(EV_RISE, 1, 0, 0);
        push(EV_WDOG, 0, 0, 0);
        push(EV_IDLE, 0, 0, 0);
        go(1, 1'b0);
        wait_q(0, 1500, "wdog_events");
        chk("wdog_busy", int'(busy), 0);
        auto_en = 1'b1;
`else
        chk("wdog_tied_low", int'(wdog_err), 0);
`endif

        // Asynchronous reset in RUN, then table must read back empty.
        wr(0, 2, 3);
        push(EV_RISE, 3, 0, 0);
        go(1, 1'b0);
        wait_q(0, 500, "prereset_rise");
        cycles(250);
        chk("prereset_cpi_cnt", int'(cpi_cnt), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_enable", int'(tg_enable), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_mode_t", int'(mode_t), 0);
        chk("async_rst_cpi_cnt", int'(cpi_cnt), 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        push(EV_DONE, 0, 0, -1);
        push(EV_IDLE, 0, 0, 0);
        go(2, 1'b1);
        wait_q(0, 100, "cleared_table_events");

        cycles(5);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
